// File: rtl/load_store_drain_if.sv
// Handshake bundle between the loading/requesting side and the store/drain block.
interface load_store_drain_if #(
    parameter int CBITS = 14
);
    logic             full_in;
    logic             rd_req;
    logic [CBITS-1:0] level;
    logic             rd_ack;
    logic             rd_err;
    logic             empty;
    logic             done;
    logic             ovf;

    // Requesting side: drives fill and read requests, observes status.
    modport master (
        output full_in, rd_req,
        input  level, rd_ack, rd_err, empty, done, ovf
    );

    // Store side: consumes requests, reports level and pulses.
    modport slave (
        input  full_in, rd_req,
        output level, rd_ack, rd_err, empty, done, ovf
    );
endinterface

// File: rtl/load_store_drain.sv
// Volume store: a fill event loads N units, each accepted read removes one.
// Three-state controller (IDLE / READY / DRAIN), every output registered.
module load_store_drain #(
    parameter int N     = 10000,
    parameter int CBITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    load_store_drain_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CBITS-1:0] FULL_LVL = CBITS'(N);
    localparam logic [CBITS-1:0] ONE      = CBITS'(1);

    state_t           state;
    logic [CBITS-1:0] level_q;
    logic             empty_q;
    logic             ack_q;
    logic             err_q;
    logic             done_q;
    logic             ovf_q;

    // Controller: state, level and all status outputs update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            level_q <= '0;
            empty_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // Pulses default low; set only in the cycle they apply.
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Nothing to hand out yet: any request is refused, even one
                    // arriving with the fill, so the fresh load stays at N.
                    if (bus.rd_req)
                        err_q <= 1'b1;
                    if (bus.full_in) begin
                        level_q <= FULL_LVL;
                        empty_q <= (FULL_LVL == '0);
                        state   <= READY;
                    end
                end
                READY, DRAIN: begin
                    // A second fill while holding stock is an overrun; flag it
                    // but leave the level alone.
                    if (bus.full_in)
                        ovf_q <= 1'b1;
                    if (bus.rd_req) begin
                        if (level_q != '0) begin
                            level_q <= level_q - ONE;
                            ack_q   <= 1'b1;
                            if (level_q == ONE) begin
                                done_q  <= 1'b1;
                                empty_q <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state   <= DRAIN;
                            end
                        end else begin
                            // Unreachable with a consistent level; refuse rather
                            // than wrap below zero.
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.level  = level_q;
    assign bus.empty  = empty_q;
    assign bus.rd_ack = ack_q;
    assign bus.rd_err = err_q;
    assign bus.done   = done_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_load_store_drain.sv
// Randomised + directed bench for load_store_drain with a queue scoreboard.
module tb_load_store_drain;
    localparam int N     = 4;
    localparam int CBITS = 14;

    typedef struct packed {
        logic [CBITS-1:0] level;
        logic             ack;
        logic             err;
        logic             empty;
        logic             done;
        logic             ovf;
    } obs_t;

    logic clk;
    logic rst;

    load_store_drain_if #(.CBITS(CBITS)) bus ();

    load_store_drain #(.N(N), .CBITS(CBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    // Reference model: plain integers describing the store's contents.
    int m_lvl    = 0;
    bit m_active = 0;   // holding a load (not idle)
    bit m_ovf    = 0;

    function automatic obs_t sample();
        obs_t o;
        o.level = bus.level;
        o.ack   = bus.rd_ack;
        o.err   = bus.rd_err;
        o.empty = bus.empty;
        o.done  = bus.done;
        o.ovf   = bus.ovf;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got lvl=%0d ack=%b err=%b empty=%b done=%b ovf=%b, want lvl=%0d ack=%b err=%b empty=%b done=%b ovf=%b",
                     name, $time, got.level, got.ack, got.err, got.empty, got.done, got.ovf,
                     exp.level, exp.ack, exp.err, exp.empty, exp.done, exp.ovf);
        end
    endtask

    function automatic obs_t model_step(input bit full, input bit req);
        obs_t e;
        e = '0;
        if (!m_active) begin
            if (req) e.err = 1'b1;
            if (full) begin
                m_lvl    = N;
                m_active = 1;
            end
        end else begin
            if (full) m_ovf = 1;
            if (req && m_lvl > 0) begin
                m_lvl = m_lvl - 1;
                e.ack = 1'b1;
                if (m_lvl == 0) begin
                    e.done   = 1'b1;
                    m_active = 0;
                end
            end
        end
        e.level = CBITS'(m_lvl);
        e.empty = (m_lvl == 0);
        e.ovf   = m_ovf;
        return e;
    endfunction

    function automatic obs_t model_reset_val();
        obs_t e;
        m_lvl    = 0;
        m_active = 0;
        m_ovf    = 0;
        e        = '0;
        e.empty  = 1'b1;
        return e;
    endfunction

    // One clock of stimulus: drive inputs mid-cycle, queue the expected result.
    task automatic step(input bit full, input bit req);
        @(negedge clk);
        bus.full_in = full;
        bus.rd_req  = req;
        exp_q.push_back(model_step(full, req));
        @(posedge clk);
    endtask

    // Monitor: every edge that has a queued expectation is checked just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            compare("cycle", sample(), e);
            n_cmp++;
            if (bus.rd_ack && bus.rd_err) begin
                n_bad++;
                $display("FAIL ack_err_exclusive @%0t: got ack=1 err=1, want not both", $time);
            end
        end
    end

    initial begin
        bus.full_in = 1'b0;
        bus.rd_req  = 1'b0;
        rst = 1'b1;
        #2;
        // Reset holds outputs with no clock edge yet.
        compare("reset_state", sample(), model_reset_val());
        @(negedge clk);
        rst = 1'b0;

        // Fill then full drain with back-to-back requests.
        step(0, 0);
        step(1, 0);
        for (int i = 0; i < N; i++) step(0, 1);
        step(0, 0);

        // Refused request coinciding with fill.
        step(1, 1);
        step(0, 0);

        // Overrun at level 2 during drain, then finish draining; ovf stays.
        step(0, 1);
        step(0, 1);
        step(1, 0);
        step(0, 1);
        step(0, 1);
        step(0, 0);
        step(0, 1);   // idle refusal, ovf still set
        step(0, 0);

        // Gapped requests.
        step(1, 0);
        for (int i = 0; i < 2 * N - 1; i++) step(0, (i % 2) == 0);
        step(0, 0);

        // Async reset mid-drain at level 2 with ovf set.
        step(1, 0);
        step(1, 1);
        step(0, 1);
        @(negedge clk);
        bus.full_in = 1'b0;
        bus.rd_req  = 1'b1;
        #2 rst = 1'b1;
        #1;
        compare("async_reset_mid_drain", sample(), model_reset_val());
        @(posedge clk);
        #2;
        compare("reset_held_over_edge", sample(), model_reset_val());
        @(negedge clk);
        rst = 1'b0;
        // First edge after release evaluates inputs: request in idle is refused.
        step(0, 1);
        step(0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 65));
        step(0, 0);
        @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drained: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
